// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Imported by the serial_adder top.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/serial_adder_half_adder.sv
// Combinational half-adder cell.
// Two of these plus an OR form one full-adder bit slice.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first bit pairs in, serial sum out,
// with the completed word collected in parallel.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             out_valid,
  output logic             sum_bit,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_word,
  output logic             carry_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               carry_q;
  logic [WIDTH-2:0]   sr;
  logic               cin;
  logic               s0;
  logic               c0;
  logic               s;
  logic               c1;
  logic               c;
  logic [WIDTH-1:0]   word;

  // A fresh word never inherits the previous word's carry.
  assign cin = (cnt == '0) ? 1'b0 : carry_q;

  half_adder u_ha0 (
    .a (a_bit),
    .b (b_bit),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  assign c    = c0 | c1;
  assign word = {s, sr};
  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry_q   <= 1'b0;
      sr        <= '0;
      out_valid <= 1'b0;
      sum_bit   <= 1'b0;
      done      <= 1'b0;
      sum_word  <= '0;
      carry_out <= 1'b0;
    end else begin
      out_valid <= in_valid;
      done      <= 1'b0;
      if (in_valid) begin
        sum_bit <= s;
        sr      <= word[WIDTH-1:1];
        case (state)
          IDLE: begin
            state   <= RUN;
            cnt     <= CNT_W'(1);
            carry_q <= c;
          end
          RUN: begin
            if (cnt == LAST) begin
              state     <= IDLE;
              cnt       <= '0;
              carry_q   <= 1'b0;
              done      <= 1'b1;
              sum_word  <= word;
              carry_out <= c;
            end else begin
              cnt     <= cnt + CNT_W'(1);
              carry_q <= c;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and seeded-random checks for serial_adder, WIDTH=4.
// Expected values are hand-computed or taken from a+b.
module tb_serial_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         a_bit;
  logic         b_bit;
  logic         out_valid;
  logic         sum_bit;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_word;
  logic         carry_out;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .out_valid (out_valid),
    .sum_bit   (sum_bit),
    .busy      (busy),
    .done      (done),
    .sum_word  (sum_word),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic a, input logic b);
    in_valid = v;
    a_bit    = a;
    b_bit    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a_bit    = 1'b0;
    b_bit    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_valid, done, busy, carry_out, sum_word} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got ov=%b d=%b busy=%b co=%b sw=%h want all 0",
               out_valid, done, busy, carry_out, sum_word);
    end
    rst_n = 1'b1;
    drive(0, 0, 0);
    total++;
    if ({out_valid, done, busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_release got ov=%b d=%b busy=%b want 000",
               out_valid, done, busy);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] exps;
    int busy_n;
    av     = 4'd3;
    bv     = 4'd5;
    exps   = 4'b1000;
    busy_n = 0;
    for (int i = 0; i < W; i++) begin
      drive(1, av[i], bv[i]);
      total++;
      if (out_valid !== 1'b1 || sum_bit !== exps[i]) begin
        bad++;
        $display("FAIL basic_bit%0d got ov=%b s=%b want ov=1 s=%b",
                 i, out_valid, sum_bit, exps[i]);
      end
      total++;
      if (done !== (i == W - 1)) begin
        bad++;
        $display("FAIL basic_done%0d got %b want %b", i, done, i == W - 1);
      end
      if (busy) busy_n++;
    end
    total++;
    if (sum_word !== 4'd8 || carry_out !== 1'b0) begin
      bad++;
      $display("FAIL basic_word got %b/%h want 0/8", carry_out, sum_word);
    end
    total++;
    if (busy_n != 3) begin
      bad++;
      $display("FAIL basic_busy got %0d cycles want 3", busy_n);
    end
    drive(0, 0, 0);
    total++;
    if (done !== 1'b0 || out_valid !== 1'b0 || sum_word !== 4'd8) begin
      bad++;
      $display("FAIL basic_after got d=%b ov=%b sw=%h want d=0 ov=0 sw=8",
               done, out_valid, sum_word);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av;
    logic [W-1:0] bv;
    av = 4'd15;
    bv = 4'd1;
    for (int i = 0; i < W; i++) drive(1, av[i], bv[i]);
    total++;
    if (done !== 1'b1 || sum_word !== 4'd0 || carry_out !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first got d=%b co=%b sw=%h want d=1 co=1 sw=0",
               done, carry_out, sum_word);
    end
    for (int i = 0; i < W; i++) begin
      drive(1, 1'b0, 1'b0);
      total++;
      if (sum_bit !== 1'b0) begin
        bad++;
        $display("FAIL b2b_leak_bit%0d got %b want 0", i, sum_bit);
      end
    end
    total++;
    if (done !== 1'b1 || sum_word !== 4'd0 || carry_out !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second got d=%b co=%b sw=%h want d=1 co=0 sw=0",
               done, carry_out, sum_word);
    end
    drive(0, 0, 0);
  endtask

  task automatic test_bubble();
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [5:0]   pat;
    int bit_i;
    int pulses;
    int done_cyc;
    logic s1;
    av       = 4'd3;
    bv       = 4'd5;
    pat      = 6'b110011;
    bit_i    = 0;
    pulses   = 0;
    done_cyc = -1;
    s1       = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k < 6 && pat[k]) begin
        drive(1, av[bit_i], bv[bit_i]);
        bit_i++;
      end else begin
        drive(0, 0, 0);
      end
      if (out_valid) pulses++;
      if (done) done_cyc = k + 1;
      if (k == 1) s1 = sum_bit;
      if (k == 2 || k == 3) begin
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || sum_bit !== s1) begin
          bad++;
          $display("FAIL bubble_hold%0d got busy=%b ov=%b s=%b want 1 0 %b",
                   k, busy, out_valid, sum_bit, s1);
        end
      end
    end
    total++;
    if (pulses != 4) begin
      bad++;
      $display("FAIL bubble_pulses got %0d want 4", pulses);
    end
    total++;
    if (done_cyc != 6) begin
      bad++;
      $display("FAIL bubble_done_cycle got %0d want 6", done_cyc);
    end
    total++;
    if (sum_word !== 4'd8 || carry_out !== 1'b0) begin
      bad++;
      $display("FAIL bubble_word got %b/%h want 0/8", carry_out, sum_word);
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] av;
    logic [W-1:0] bv;
    drive(1, 1'b1, 1'b1);
    drive(1, 1'b1, 1'b1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    total++;
    if (busy !== 1'b0 || sum_word !== 4'd0 || done !== 1'b0 ||
        carry_out !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state got busy=%b sw=%h d=%b co=%b want 0",
               busy, sum_word, done, carry_out);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    av = 4'd3;
    bv = 4'd5;
    for (int i = 0; i < W; i++) begin
      drive(1, av[i], bv[i]);
      total++;
      if (done !== (i == W - 1)) begin
        bad++;
        $display("FAIL midrst_done%0d got %b want %b", i, done, i == W - 1);
      end
    end
    total++;
    if (sum_word !== 4'd8 || carry_out !== 1'b0) begin
      bad++;
      $display("FAIL midrst_word got %b/%h want 0/8", carry_out, sum_word);
    end
    drive(0, 0, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] av;
    logic [W:0]   gold;
    logic [W-1:0] bv;
    int gap;
    bit stop;
    stop = 1'b0;
    void'($urandom(32'd1234));
    for (int w = 0; w < 100 && !stop; w++) begin
      av   = W'($urandom_range(0, 15));
      bv   = W'($urandom_range(0, 15));
      gold = {1'b0, av} + {1'b0, bv};
      for (int i = 0; i < W; i++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) drive(0, 0, 0);
        drive(1, av[i], bv[i]);
      end
      total++;
      if (done !== 1'b1 || {carry_out, sum_word} !== gold) begin
        bad++;
        stop = 1'b1;
        $display("FAIL random_word%0d a=%0d b=%0d got d=%b sum=%0d want d=1 sum=%0d",
                 w, av, bv, done, {carry_out, sum_word}, gold);
      end
    end
    drive(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_bubble();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder stage that consumes operand bit pairs LSB-first and produces one sum bit per accepted pair.
- Each bit pair is added with a carry flip-flop, so a WIDTH-bit addition is built from the team's combinational half_adder cell.
- Collects the serial result into a parallel word and flags completion.
- Sits directly downstream of the half_adder cell: it is the sequential consumer of that cell's sum/carry.

Parameters:
- WIDTH, 4, operand word length in bits; legal range WIDTH >= 2.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a_bit/b_bit are valid this cycle.
- a_bit  input  1  operand A bit, LSB first.
- b_bit  input  1  operand B bit, LSB first.
- out_valid  output  1  sum_bit is valid; registered.
- sum_bit  output  1  serial sum bit, LSB first.
- busy  output  1  a word is partially received.
- done  output  1  one-cycle pulse: sum_word and carry_out were updated this cycle.
- sum_word  output  WIDTH  parallel result of the last completed word.
- carry_out  output  1  final carry of the last completed word.

Behaviour:
- Reset (async assert, sync release): cnt=0, carry_q=0, state IDLE. All outputs are 0 during reset.
- States:
  - IDLE: cnt==0, no word open.
  - RUN: 0<cnt<=WIDTH-1.
  - IDLE->RUN on an accepted first bit.
  - RUN->IDLE on an accepted bit with cnt==WIDTH-1.
- busy=1 exactly in RUN.
- Accept rule: a bit pair is accepted on any rising edge with in_valid=1. There is no backpressure; the block is always ready.
- Arithmetic per accepted bit:
  - cin = (cnt==0) ? 0 : carry_q.
  - {c, s} = a_bit + b_bit + cin, built as two half_adder instances plus an OR for the carry.
- Latency: s appears on sum_bit with out_valid=1 on the cycle after acceptance, i.e. 1 cycle.
- in_valid=0: cnt, carry_q, state and shift register hold. Next cycle out_valid=0 and sum_bit holds its last value.
- Shift register: on each accept, sr <= {s, sr[WIDTH-1:1]}, so the LSB-first stream lands in bit order.
- On accept with cnt==WIDTH-1, on the next cycle:
  - done=1 for exactly one cycle.
  - sum_word = {s, sr[WIDTH-1:1]}.
  - carry_out = c.
  - cnt wraps to 0 and carry_q is cleared.
- sum_word and carry_out hold until the next done.
- Back-to-back words: the first bit of the next word may be accepted in the cycle right after the last bit. It uses cin=0, never the previous word's carry.
- Reset mid-word: the partial word is discarded. sum_word/carry_out clear to 0, done is not pulsed, and the next accepted bit starts a fresh word.
- done and out_valid are asserted together on a word's final bit.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN}.
  - Default WIDTH constant.
- Natural sub-module: half_adder (existing cell, instantiated twice). No other hierarchy.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> out_valid=0, done=0, busy=0, sum_word=0, carry_out=0.
- WIDTH=4, A=3, B=5, four consecutive valid cycles -> sum_bit stream 0,0,0,1; done one cycle after the 4th bit; sum_word=4'b1000; carry_out=0; busy high for 3 cycles.
- A=15, B=1 -> sum_word=0, carry_out=1; then immediately A=0, B=0 back-to-back -> sum_word=0, carry_out=0 (no carry leak).
- A=3, B=5 with in_valid low for 2 cycles between bits 1 and 2 -> exactly 4 out_valid pulses; same result 8/0; done occurs 2 cycles later than the unbroken case.
- Reset pulse after 2 accepted bits of A=15, B=15 -> busy=0, sum_word=0, no done; a following full word A=3, B=5 -> sum_word=8, carry_out=0.
- 100 random words (fixed seed), random bubbles -> {carry_out, sum_word} equals the golden A+B at every done; fail and stop on first mismatch.
